mlp_layer_controller: RTL and testbench
=======================================

# mlp_layer_controller

Sequencer for a full fully-connected MLP layer. It steps through NEURON_NUM neurons of INPUT_NUM inputs each and generates weight and input SRAM read addresses. It waits on a read-data-valid handshake, so SRAM latency can vary, and drives accumulator clear and enable, activation routing and one output write per neuron. It sits between the weight/input SRAMs and the MAC/activation datapath, and replaces the single-neuron controller for layer-level operation.

## Interface
Parameters:
- INPUT_NUM, 8, inputs per neuron (≥1)
- NEURON_NUM, 4, neurons per layer (≥1)
- ADDR_WIDTH, 8, width of all address outputs; must satisfy NEURON_NUM*(INPUT_NUM+1) ≤ 2^ADDR_WIDTH

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- abort  in  1  synchronous abandon; returns to IDLE, no further writes
- rd_valid  in  1  SRAM read data valid for the outstanding read
- read_enable  out  1  issue read to both SRAMs
- weight_addr  out  ADDR_WIDTH  weight SRAM address
- input_addr  out  ADDR_WIDTH  input SRAM address
- acc_clear  out  1  zero the accumulator
- acc_enable  out  1  accumulate current read data
- mux_select  out  1  1 = accumulator adds bias operand instead of product
- demux_select  out  1  1 = route accumulator through activation to output register
- write_enable  out  1  write activated result
- out_addr  out  ADDR_WIDTH  output SRAM address (= neuron index)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, layer complete

## Operation
- Counters: in_idx (0..INPUT_NUM-1), n_idx (0..NEURON_NUM-1), zero-extended to ADDR_WIDTH.
- IDLE: all outputs 0. If start is 1, clear n_idx and go to CLEAR.
- CLEAR: acc_clear=1; in_idx←0; go to READ.
- READ: read_enable=1; weight_addr=n_idx*INPUT_NUM+in_idx; input_addr=in_idx; go to WAIT.
- WAIT: hold both addresses. While rd_valid is 0, stay. When rd_valid is 1, acc_enable=1 in that cycle. If in_idx=INPUT_NUM-1, go to BIAS_RD (bias compiled in) or ACT. Otherwise in_idx++ and go to READ.
- BIAS_RD (bias only): read_enable=1; weight_addr=NEURON_NUM*INPUT_NUM+n_idx; mux_select=1; go to BIAS_WAIT.
- BIAS_WAIT (bias only): hold weight_addr and mux_select=1. When rd_valid is 1, acc_enable=1 and go to ACT.
- ACT: demux_select=1; go to WRITE.
- WRITE: write_enable=1; out_addr=n_idx. If n_idx=NEURON_NUM-1, go to DONE. Otherwise n_idx++ and go to CLEAR.
- DONE: done=1; go to IDLE.
- Address and select outputs are 0 in every state not listed above for them.
- start outside IDLE is ignored.
- rd_valid outside WAIT/BIAS_WAIT is ignored and causes no acc_enable.
- abort=1 in any non-IDLE state: next state IDLE, counters cleared. Outputs in that cycle are still the current state's decode, except write_enable and done, which are forced to 0. abort has priority over all transitions.
- start and abort together in IDLE: remain in IDLE.

## Timing
- Async reset: state IDLE, counters 0, all outputs 0 immediately on reset low. Release is synchronous to clk; the first start is accepted on the first rising edge with reset high.
- Outputs decode from state and counters. acc_enable is combinational from rd_valid in the wait states. There is no output register stage.
- Per neuron with rd_valid high in the first WAIT cycle: 2*INPUT_NUM+3 cycles, or 2*INPUT_NUM+5 with bias. Each extra cycle rd_valid is low adds one cycle.
- done is asserted NEURON_NUM*(per-neuron cycles) cycles after the edge that samples start. busy falls on the edge after done.
- Only one read is outstanding at a time; a new read_enable is never issued before the previous rd_valid.

## Configuration
- MLP_CTRL_BIAS_EN defined: BIAS_RD/BIAS_WAIT are present. The bias for neuron n is read from weight address NEURON_NUM*INPUT_NUM+n and accumulated with mux_select=1.
- Undefined: bias states are absent, mux_select is constant 0, and WAIT goes directly to ACT after the last input.

## Test plan
- INPUT_NUM=8, NEURON_NUM=4, no bias, rd_valid tied 1, start pulse -> weight_addr sequence 0..31; out_addr 0,1,2,3 with one write_enable each; done 76 cycles after start edge.
- Same configuration, MLP_CTRL_BIAS_EN defined -> bias reads at weight_addr 32..35 with mux_select=1; done at 84 cycles.
- rd_valid delayed 3 cycles on input 5 of neuron 2 -> addresses held stable throughout; exactly one acc_enable for that read; done at 79 cycles.
- abort asserted during WAIT of neuron 1 -> IDLE next cycle; no write_enable for neuron 1; no done; busy=0.
- reset driven low mid-layer during WRITE -> all outputs 0 immediately; a new start after release restarts at weight_addr 0.
- start held high continuously, INPUT_NUM=1, NEURON_NUM=1 -> done after 5 cycles; a new layer starts on the edge after the return to IDLE; start while busy is ignored.

Source files
------------

// File: rtl/mlp_layer_controller.sv
// mlp_layer_controller: layer-level sequencer for a fully-connected MLP layer.
// Walks NEURON_NUM neurons of INPUT_NUM inputs each, issues one SRAM read at a
// time and waits for rd_valid, then drives accumulator control, activation
// routing and one output write per neuron.
// Optional feature: define MLP_CTRL_BIAS_EN to add a bias read per neuron
// (bias for neuron n lives at weight address NEURON_NUM*INPUT_NUM+n).
module mlp_layer_controller #(
  parameter int INPUT_NUM  = 8,
  parameter int NEURON_NUM = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  rd_valid,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  acc_clear,
  output logic                  acc_enable,
  output logic                  mux_select,
  output logic                  demux_select,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLEAR     = 4'd1,
    ST_READ      = 4'd2,
    ST_WAIT      = 4'd3,
`ifdef MLP_CTRL_BIAS_EN
    ST_BIAS_RD   = 4'd4,
    ST_BIAS_WAIT = 4'd5,
`endif
    ST_ACT       = 4'd6,
    ST_WRITE     = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_IN_NUM   = ADDR_WIDTH'(INPUT_NUM);
  localparam logic [ADDR_WIDTH-1:0] LP_IN_LAST  = ADDR_WIDTH'(INPUT_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_N_LAST   = ADDR_WIDTH'(NEURON_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_BIAS_BASE = ADDR_WIDTH'(NEURON_NUM * INPUT_NUM);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_in_idx;
  logic [ADDR_WIDTH-1:0] r_n_idx;

  state_t                w_state_dec;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_in_idx_dec;
  logic [ADDR_WIDTH-1:0] w_n_idx_dec;
  logic [ADDR_WIDTH-1:0] w_in_idx_nxt;
  logic [ADDR_WIDTH-1:0] w_n_idx_nxt;
  logic                  w_write_dec;
  logic                  w_done_dec;
  logic                  w_abort_act;
  logic [ADDR_WIDTH-1:0] w_data_addr;

  assign w_data_addr = (r_n_idx * LP_IN_NUM) + r_in_idx;

  // State and counter registers; async reset returns to IDLE with counters cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_in_idx <= {ADDR_WIDTH{1'b0}};
      r_n_idx  <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_in_idx <= w_in_idx_nxt;
      r_n_idx  <= w_n_idx_nxt;
    end
  end

  // Next-state, counter updates and output decode; abort overrides transitions and suppresses write/done.
  always_comb begin
    w_state_dec  = r_state;
    w_in_idx_dec = r_in_idx;
    w_n_idx_dec  = r_n_idx;
    w_write_dec  = 1'b0;
    w_done_dec   = 1'b0;
    read_enable  = 1'b0;
    weight_addr  = {ADDR_WIDTH{1'b0}};
    input_addr   = {ADDR_WIDTH{1'b0}};
    acc_clear    = 1'b0;
    acc_enable   = 1'b0;
    mux_select   = 1'b0;
    demux_select = 1'b0;
    out_addr     = {ADDR_WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_n_idx_dec = {ADDR_WIDTH{1'b0}};
          w_state_dec = ST_CLEAR;
        end else begin
          w_state_dec = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        acc_clear    = 1'b1;
        w_in_idx_dec = {ADDR_WIDTH{1'b0}};
        w_state_dec  = ST_READ;
      end
      ST_READ: begin
        read_enable = 1'b1;
        weight_addr = w_data_addr;
        input_addr  = r_in_idx;
        w_state_dec = ST_WAIT;
      end
      ST_WAIT: begin
        weight_addr = w_data_addr;
        input_addr  = r_in_idx;
        if (rd_valid) begin
          acc_enable = 1'b1;
          if (r_in_idx == LP_IN_LAST) begin
`ifdef MLP_CTRL_BIAS_EN
            w_state_dec = ST_BIAS_RD;
`else
            w_state_dec = ST_ACT;
`endif
          end else begin
            w_in_idx_dec = r_in_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            w_state_dec  = ST_READ;
          end
        end else begin
          w_state_dec = ST_WAIT;
        end
      end
`ifdef MLP_CTRL_BIAS_EN
      ST_BIAS_RD: begin
        read_enable = 1'b1;
        weight_addr = LP_BIAS_BASE + r_n_idx;
        mux_select  = 1'b1;
        w_state_dec = ST_BIAS_WAIT;
      end
      ST_BIAS_WAIT: begin
        weight_addr = LP_BIAS_BASE + r_n_idx;
        mux_select  = 1'b1;
        if (rd_valid) begin
          acc_enable  = 1'b1;
          w_state_dec = ST_ACT;
        end else begin
          w_state_dec = ST_BIAS_WAIT;
        end
      end
`endif
      ST_ACT: begin
        demux_select = 1'b1;
        w_state_dec  = ST_WRITE;
      end
      ST_WRITE: begin
        w_write_dec = 1'b1;
        out_addr    = r_n_idx;
        if (r_n_idx == LP_N_LAST) begin
          w_state_dec = ST_DONE;
        end else begin
          w_n_idx_dec = r_n_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          w_state_dec = ST_CLEAR;
        end
      end
      ST_DONE: begin
        w_done_dec  = 1'b1;
        w_state_dec = ST_IDLE;
      end
      default: begin
        w_state_dec = ST_IDLE;
      end
    endcase

    w_abort_act  = abort && (r_state != ST_IDLE);
    w_state_nxt  = w_abort_act ? ST_IDLE : w_state_dec;
    w_in_idx_nxt = w_abort_act ? {ADDR_WIDTH{1'b0}} : w_in_idx_dec;
    w_n_idx_nxt  = w_abort_act ? {ADDR_WIDTH{1'b0}} : w_n_idx_dec;
    write_enable = w_write_dec && !w_abort_act;
    done         = w_done_dec && !w_abort_act;
    busy         = (r_state != ST_IDLE);
  end

  // Bias base is only referenced when the bias states are compiled in.
  logic w_unused_bias;
  assign w_unused_bias = ^LP_BIAS_BASE;

endmodule

// File: tb/tb_mlp_layer_controller.sv
// Directed self-checking bench for mlp_layer_controller.
// Main DUT: INPUT_NUM=8, NEURON_NUM=4. Small DUT: INPUT_NUM=1, NEURON_NUM=1.
// Expectations follow MLP_CTRL_BIAS_EN when the build defines it.
module tb_mlp_layer_controller;

`ifdef MLP_CTRL_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif
  localparam int IN = 8;
  localparam int NN = 4;
  localparam int PER = 2*IN + 3 + 2*BIAS;
  localparam int DONE_CYC = NN * PER;   // 76, or 84 with bias
  localparam int SP = 2*1 + 3 + 2*BIAS; // small DUT layer length: 5 or 7

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, rd_valid = 1'b0;
  logic read_enable, acc_clear, acc_enable, mux_select, demux_select, write_enable, busy, done;
  logic [7:0] weight_addr, input_addr, out_addr;
  logic s_start = 1'b0, s_abort = 1'b0, s_rd_valid = 1'b1;
  logic s_read_enable, s_acc_clear, s_acc_enable, s_mux_select, s_demux_select, s_write_enable, s_busy, s_done;
  logic [7:0] s_weight_addr, s_input_addr, s_out_addr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mlp_layer_controller #(.INPUT_NUM(IN), .NEURON_NUM(NN), .ADDR_WIDTH(8)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .rd_valid(rd_valid),
    .read_enable(read_enable), .weight_addr(weight_addr), .input_addr(input_addr),
    .acc_clear(acc_clear), .acc_enable(acc_enable), .mux_select(mux_select),
    .demux_select(demux_select), .write_enable(write_enable), .out_addr(out_addr),
    .busy(busy), .done(done));

  mlp_layer_controller #(.INPUT_NUM(1), .NEURON_NUM(1), .ADDR_WIDTH(8)) u_dut_s (
    .clk(clk), .reset(rst_n), .start(s_start), .abort(s_abort), .rd_valid(s_rd_valid),
    .read_enable(s_read_enable), .weight_addr(s_weight_addr), .input_addr(s_input_addr),
    .acc_clear(s_acc_clear), .acc_enable(s_acc_enable), .mux_select(s_mux_select),
    .demux_select(s_demux_select), .write_enable(s_write_enable), .out_addr(s_out_addr),
    .busy(s_busy), .done(s_done));

  // Expected weight address of the k-th read of a layer.
  function automatic int exp_rd_addr(input int k);
    int n, i;
    n = k / (IN + BIAS);
    i = k % (IN + BIAS);
    if (i == IN) return NN*IN + n;
    return n*IN + i;
  endfunction

  // Expected mux_select of the k-th read of a layer.
  function automatic logic exp_rd_mux(input int k);
    return (BIAS == 1) && ((k % (IN + BIAS)) == IN);
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if ({read_enable, weight_addr, input_addr, acc_clear, acc_enable, mux_select,
         demux_select, write_enable, out_addr, busy, done} !== 33'd0) begin
      $display("FAIL reset_outputs: got nonzero outputs busy=%b rd=%b, required all 0", busy, read_enable);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || s_busy !== 1'b0) begin
      $display("FAIL reset_release_idle: busy=%b s_busy=%b, required 0", busy, s_busy);
      n_fail++;
    end
  endtask

  task automatic test_full_layer();
    int n_rd = 0, n_wr = 0, n_acc = 0, done_cyc = -1;
    @(negedge clk); start = 1'b1; rd_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      #1;
      if (read_enable) begin
        n_checks++;
        if (weight_addr !== 8'(exp_rd_addr(n_rd)) || mux_select !== exp_rd_mux(n_rd)) begin
          $display("FAIL full_rd_addr: read %0d got addr %0d mux %b, required addr %0d mux %b",
                   n_rd, weight_addr, mux_select, exp_rd_addr(n_rd), exp_rd_mux(n_rd));
          n_fail++;
        end
        n_rd++;
      end
      if (write_enable) begin
        n_checks++;
        if (out_addr !== 8'(n_wr)) begin
          $display("FAIL full_out_addr: got %0d, required %0d", out_addr, n_wr);
          n_fail++;
        end
        n_wr++;
      end
      if (acc_enable) n_acc++;
      if (done) done_cyc = cyc;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (done_cyc != DONE_CYC) begin
      $display("FAIL full_done_cycle: got %0d, required %0d", done_cyc, DONE_CYC);
      n_fail++;
    end
    n_checks++;
    if (n_rd != NN*(IN+BIAS) || n_wr != NN || n_acc != NN*(IN+BIAS)) begin
      $display("FAIL full_counts: reads %0d writes %0d accs %0d, required %0d %0d %0d",
               n_rd, n_wr, n_acc, NN*(IN+BIAS), NN, NN*(IN+BIAS));
      n_fail++;
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL full_busy_after_done: busy=%b done=%b, required 0 0", busy, done);
      n_fail++;
    end
  endtask

  task automatic test_rd_delay();
    int n_rd = 0, done_cyc = -1, hold_left = 0, win_acc = 0, hold_bad = 0;
    int target = 2*(IN+BIAS) + 5;
    logic in_win = 1'b0;
    @(negedge clk); start = 1'b1; rd_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      if (hold_left > 0) begin
        rd_valid = 1'b0;
        hold_left--;
      end else begin
        rd_valid = 1'b1;
      end
      #1;
      if (!rd_valid && (weight_addr !== 8'(2*IN+5) || input_addr !== 8'd5 || acc_enable !== 1'b0))
        hold_bad++;
      if (read_enable) begin
        in_win = (n_rd == target);
        if (n_rd == target) hold_left = 3;
        n_rd++;
      end
      if (in_win && acc_enable) win_acc++;
      if (done) done_cyc = cyc;
      @(negedge clk);
    end
    rd_valid = 1'b1;
    n_checks++;
    if (hold_bad != 0) begin
      $display("FAIL delay_addr_hold: %0d bad wait cycles, required 0", hold_bad);
      n_fail++;
    end
    n_checks++;
    if (win_acc != 1) begin
      $display("FAIL delay_acc_once: got %0d acc_enable pulses, required 1", win_acc);
      n_fail++;
    end
    n_checks++;
    if (done_cyc != DONE_CYC + 3) begin
      $display("FAIL delay_done_cycle: got %0d, required %0d", done_cyc, DONE_CYC + 3);
      n_fail++;
    end
  endtask

  task automatic test_abort();
    int n_wr = 0, bad = 0;
    logic fire = 1'b0, seen = 1'b0;
    // start and abort together in IDLE stay in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL abort_start_idle: busy=%b, required 0", busy);
      n_fail++;
    end
    // abort in WAIT of neuron 1
    @(negedge clk); start = 1'b1; rd_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (fire) abort = 1'b1;
      #1;
      if (write_enable) n_wr++;
      if (fire) begin
        seen = 1'b1;
        n_checks++;
        if (weight_addr !== 8'd8 || acc_enable !== 1'b1 || write_enable !== 1'b0) begin
          $display("FAIL abort_wait_decode: addr %0d acc %b we %b, required 8 1 0",
                   weight_addr, acc_enable, write_enable);
          n_fail++;
        end
      end
      if (read_enable && weight_addr == 8'd8) fire = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || read_enable !== 1'b0 || !seen) begin
      $display("FAIL abort_idle: busy=%b rd=%b seen=%b, required 0 0 1", busy, read_enable, seen);
      n_fail++;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (write_enable || done || busy) bad++;
    end
    n_checks++;
    if (n_wr != 1 || bad != 0) begin
      $display("FAIL abort_no_writes: writes %0d bad %0d, required 1 0", n_wr, bad);
      n_fail++;
    end
    // abort in WRITE of neuron 0 suppresses the write
    seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      #1;
      if (demux_select) begin
        @(negedge clk);
        abort = 1'b1;
        #1;
        seen = 1'b1;
        n_checks++;
        if (write_enable !== 1'b0 || out_addr !== 8'd0 || busy !== 1'b1) begin
          $display("FAIL abort_write_suppress: we %b busy %b, required 0 1", write_enable, busy);
          n_fail++;
        end
      end
      @(negedge clk);
    end
    abort = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || !seen) begin
      $display("FAIL abort_write_idle: busy=%b seen=%b, required 0 1", busy, seen);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    @(negedge clk); start = 1'b1; rd_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      #1;
      if (write_enable) begin
        seen = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({read_enable, weight_addr, input_addr, acc_clear, acc_enable, mux_select,
             demux_select, write_enable, out_addr, busy, done} !== 33'd0) begin
          $display("FAIL reset_mid_outputs: we=%b busy=%b out_addr=%0d, required all 0",
                   write_enable, busy, out_addr);
          n_fail++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL reset_mid_reach_write: write never seen, required a write");
      n_fail++;
    end
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || acc_clear !== 1'b1) begin
      $display("FAIL reset_first_start: busy=%b clear=%b, required 1 1", busy, acc_clear);
      n_fail++;
    end
    @(negedge clk); #1;
    n_checks++;
    if (read_enable !== 1'b1 || weight_addr !== 8'd0 || input_addr !== 8'd0) begin
      $display("FAIL reset_restart_addr: rd=%b waddr=%0d iaddr=%0d, required 1 0 0",
               read_enable, weight_addr, input_addr);
      n_fail++;
    end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    int done1 = -1, done2 = -1, clr1 = 0, rd1 = 0;
    logic idle_gap = 1'b0, clr_second = 1'b0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc <= 2*SP + 2; cyc++) begin
      #1;
      if (s_done) begin
        if (done1 < 0) done1 = cyc;
        else if (done2 < 0) done2 = cyc;
      end
      if (cyc <= SP && s_acc_clear) clr1++;
      if (cyc <= SP && s_read_enable) rd1++;
      if (cyc == SP + 1) idle_gap = !s_busy;
      if (cyc == SP + 2) clr_second = s_acc_clear;
      @(negedge clk);
    end
    s_start = 1'b0;
    #1;
    n_checks++;
    if (done1 != SP || done2 != 2*SP + 2) begin
      $display("FAIL b2b_done_cycles: got %0d %0d, required %0d %0d", done1, done2, SP, 2*SP + 2);
      n_fail++;
    end
    n_checks++;
    if (clr1 != 1 || rd1 != 1 + BIAS) begin
      $display("FAIL b2b_start_ignored: clears %0d reads %0d, required 1 %0d", clr1, rd1, 1 + BIAS);
      n_fail++;
    end
    n_checks++;
    if (!idle_gap || !clr_second) begin
      $display("FAIL b2b_restart: idle_gap %b clear_after %b, required 1 1", idle_gap, clr_second);
      n_fail++;
    end
    n_checks++;
    if (s_busy !== 1'b0) begin
      $display("FAIL b2b_final_idle: busy=%b, required 0", s_busy);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_rd_delay();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
